// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory request/response
// channel, decode-side output channel and the misalignment pulse.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus_4;

  logic            misalign_err;

  // The fetch unit itself
  modport master (
    input  redirect_valid, redirect_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  out_ready,
    output mem_req_valid, mem_req_addr,
    output out_valid, out_instr, out_pc, out_pc_plus_4,
    output misalign_err
  );

  // The environment around it: memory, decode and branch resolution
  modport slave (
    output redirect_valid, redirect_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output out_ready,
    input  mem_req_valid, mem_req_addr,
    input  out_valid, out_instr, out_pc, out_pc_plus_4,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks in-flight
// requests, queues returned instructions with their PC and discards responses
// belonging to fetches made before a redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam int              SW      = CW + 1;
  localparam logic [SW-1:0]   DEPTH_S = SW'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occupancy;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            req_en;
  logic            mis_q;

  logic            accept;
  logic            rsp;
  logic            drop_rsp;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding_next;
  logic [XLEN-1:0] redirect_target;

  // Handshake decode; responses are never queued during a redirect cycle
  always_comb begin
    accept           = bus.mem_req_valid & bus.mem_req_ready;
    rsp              = bus.mem_rsp_valid;
    drop_rsp         = rsp & (drop_cnt != '0);
    push             = rsp & ~drop_rsp & ~bus.redirect_valid;
    pop              = bus.out_valid & bus.out_ready;
    outstanding_next = outstanding + CW'(accept) - CW'(rsp);
    redirect_target  = {bus.redirect_pc[XLEN-1:2], 2'b00};
  end

  // Requests come purely from registers; req_en keeps them off while in reset
  assign bus.mem_req_valid = req_en &
                             (({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH_S);
  assign bus.mem_req_addr  = fetch_pc;

  assign bus.out_valid     = (occupancy != '0);
  assign bus.out_instr     = bus.out_valid ? instr_mem[rd_ptr]       : '0;
  assign bus.out_pc        = bus.out_valid ? pc_mem[rd_ptr]          : '0;
  assign bus.out_pc_plus_4 = bus.out_valid ? pc_mem[rd_ptr] + STEP   : '0;
  assign bus.misalign_err  = mis_q;

  // Fetch PC: jumps to the aligned target on redirect, else steps per acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_en   <= 1'b0;
    end else begin
      req_en <= 1'b1;
      if (bus.redirect_valid) begin
        fetch_pc <= redirect_target;
      end else if (accept) begin
        fetch_pc <= fetch_pc + STEP;
      end
    end
  end

  // In-flight accounting; on redirect everything still in flight becomes stale
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.redirect_valid) begin
        drop_cnt <= outstanding_next;
      end else if (drop_rsp) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Queue pointers, occupancy and the PC that the next kept response belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      resp_pc   <= RESET_PC;
    end else if (bus.redirect_valid) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      resp_pc   <= redirect_target;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Queue storage; contents are masked at the outputs while the queue is empty
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem[wr_ptr] <= bus.mem_rsp_data;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

  // One-cycle pulse following a redirect to a non-word-aligned target
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-configurable in-order memory
// model, a scoreboard of expected instructions, and one task per scenario.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          acc_count = 0;
  int          pop_count = 0;
  int          mis_count = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        mis_pending = 1'b0;
  pend_t       pend[$];
  exp_t        sb[$];
  logic [31:0] acc_addrs[$];
  logic [31:0] pop_pcs[$];
  logic [31:0] pop_p4[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and scoreboard; samples 1ns after each falling edge
  initial begin
    pend_t       p;
    exp_t        e;
    logic [31:0] exp_p4;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.misalign_err !== mis_pending) begin
        $display("[TB] FAIL misalign_err: got %b, expected %b", bus.misalign_err, mis_pending);
      end else begin
        passes++;
      end
      if (bus.misalign_err === 1'b1) mis_count++;
      if (rst) begin
        pend.delete();
        sb.delete();
        acc_addrs.delete();
        pop_pcs.delete();
        pop_p4.delete();
        exp_pc            = 32'h0;
        mis_pending       = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = mem_word(p.addr);
        end else begin
          bus.mem_rsp_valid = 1'b0;
          bus.mem_rsp_data  = 32'h0;
        end
        if (bus.out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL out_unexpected: got out_valid=1 out_pc=%h, expected out_valid=0", bus.out_pc);
          end else begin
            exp_p4 = sb[0].pc + 32'd4;
            checks++;
            if (bus.out_pc !== sb[0].pc) begin
              $display("[TB] FAIL out_pc: got %h, expected %h", bus.out_pc, sb[0].pc);
            end else passes++;
            checks++;
            if (bus.out_instr !== sb[0].instr) begin
              $display("[TB] FAIL out_instr: got %h, expected %h", bus.out_instr, sb[0].instr);
            end else passes++;
            checks++;
            if (bus.out_pc_plus_4 !== exp_p4) begin
              $display("[TB] FAIL out_pc_plus_4: got %h, expected %h", bus.out_pc_plus_4, exp_p4);
            end else passes++;
            if (bus.out_ready) begin
              e = sb.pop_front();
              pop_count++;
              pop_pcs.push_back(bus.out_pc);
              pop_p4.push_back(bus.out_pc_plus_4);
            end
          end
        end
        if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready) begin
          checks++;
          if (bus.mem_req_addr !== exp_pc) begin
            $display("[TB] FAIL mem_req_addr: got %h, expected %h", bus.mem_req_addr, exp_pc);
          end else passes++;
          acc_count++;
          acc_addrs.push_back(bus.mem_req_addr);
          pend.push_back('{addr: bus.mem_req_addr, due: cyc + mem_lat});
          sb.push_back('{pc: bus.mem_req_addr, instr: mem_word(bus.mem_req_addr)});
          exp_pc = exp_pc + 32'd4;
        end
        if (bus.redirect_valid) begin
          sb.delete();
          acc_addrs.delete();
          pop_pcs.delete();
          pop_p4.delete();
          exp_pc = {bus.redirect_pc[31:2], 2'b00};
        end
        mis_pending = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      end
      cyc++;
    end
  end

  // Hard stop in case a scenario never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0033;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++; if (bus.mem_req_valid !== 1'b0) $display("[TB] FAIL rst_req_valid: got %b, expected 0", bus.mem_req_valid); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b, expected 0", bus.out_valid); else passes++;
    checks++; if (bus.misalign_err !== 1'b0) $display("[TB] FAIL rst_misalign: got %b, expected 0", bus.misalign_err); else passes++;
    checks++; if (bus.out_instr !== 32'h0) $display("[TB] FAIL rst_out_instr: got %h, expected 0", bus.out_instr); else passes++;
    checks++; if (bus.out_pc !== 32'h0) $display("[TB] FAIL rst_out_pc: got %h, expected 0", bus.out_pc); else passes++;
    checks++; if (bus.out_pc_plus_4 !== 32'h0) $display("[TB] FAIL rst_out_pc_plus_4: got %h, expected 0", bus.out_pc_plus_4); else passes++;
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b0) $display("[TB] FAIL rst_hold_req_valid: got %b, expected 0", bus.mem_req_valid); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b1) $display("[TB] FAIL release_req_valid: got %b, expected 1", bus.mem_req_valid); else passes++;
    checks++; if (bus.mem_req_addr !== 32'h0) $display("[TB] FAIL release_req_addr: got %h, expected 0", bus.mem_req_addr); else passes++;
  endtask

  task automatic test_basic();
    int          first_req;
    int          first_out;
    logic [31:0] first_pc;
    logic [31:0] first_p4;
    first_req = -1;
    first_out = -1;
    first_pc  = 32'hx;
    first_p4  = 32'hx;
    mem_lat = 1;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (first_req < 0 && bus.mem_req_valid === 1'b1) first_req = i;
      if (first_out < 0 && bus.out_valid === 1'b1) begin
        first_out = i;
        first_pc  = bus.out_pc;
        first_p4  = bus.out_pc_plus_4;
      end
      @(negedge clk);
    end
    checks++; if (first_req < 0 || first_out - first_req != 2) $display("[TB] FAIL basic_latency: got %0d, expected 2", first_out - first_req); else passes++;
    checks++; if (first_pc !== 32'h0) $display("[TB] FAIL basic_first_pc: got %h, expected 0", first_pc); else passes++;
    checks++; if (first_p4 !== 32'h4) $display("[TB] FAIL basic_first_pc_plus_4: got %h, expected 4", first_p4); else passes++;
    checks++; if (pop_count < 10) $display("[TB] FAIL basic_throughput: got %0d pops, expected at least 10", pop_count); else passes++;
  endtask

  task automatic test_full();
    int a0;
    int p0;
    mem_lat = 1;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b0;
    do_reset();
    a0 = acc_count;
    repeat (20) @(negedge clk);
    checks++; if (acc_count - a0 != 4) $display("[TB] FAIL full_accepts: got %0d, expected 4", acc_count - a0); else passes++;
    checks++; if (bus.mem_req_valid !== 1'b0) $display("[TB] FAIL full_req_valid: got %b, expected 0", bus.mem_req_valid); else passes++;
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL full_out_valid: got %b, expected 1", bus.out_valid); else passes++;
    p0 = pop_count;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pop_count - p0 != 4) $display("[TB] FAIL full_drain: got %0d, expected 4", pop_count - p0); else passes++;
    repeat (10) @(negedge clk);
    checks++; if (acc_count - a0 <= 4) $display("[TB] FAIL full_resume: got %0d accepts, expected more than 4", acc_count - a0); else passes++;
  endtask

  task automatic test_redirect();
    int a0;
    bit hit;
    mem_lat = 3;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    do_reset();
    a0  = acc_count;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (acc_count - a0 >= 3) hit = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!hit) $display("[TB] FAIL redirect_wait: got %0d accepts, expected 3", acc_count - a0); else passes++;
    bus.mem_req_ready = 1'b0;
    redirect_to(32'h0000_0100);
    bus.mem_req_ready = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (acc_addrs.size() == 0 || acc_addrs[0] !== 32'h100) $display("[TB] FAIL redirect_req_addr: got %h, expected 100", acc_addrs.size() ? acc_addrs[0] : 32'hx); else passes++;
    checks++; if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h100) $display("[TB] FAIL redirect_first_pc: got %h, expected 100", pop_pcs.size() ? pop_pcs[0] : 32'hx); else passes++;
  endtask

  task automatic test_misalign();
    int m0;
    mem_lat = 2;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    m0 = mis_count;
    redirect_to(32'h0000_0102);
    repeat (20) @(negedge clk);
    checks++; if (mis_count - m0 != 1) $display("[TB] FAIL misalign_pulses: got %0d, expected 1", mis_count - m0); else passes++;
    checks++; if (acc_addrs.size() == 0 || acc_addrs[0] !== 32'h100) $display("[TB] FAIL misalign_req_addr: got %h, expected 100", acc_addrs.size() ? acc_addrs[0] : 32'hx); else passes++;
    checks++; if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h100) $display("[TB] FAIL misalign_first_pc: got %h, expected 100", pop_pcs.size() ? pop_pcs[0] : 32'hx); else passes++;
  endtask

  task automatic test_collision();
    int a0;
    mem_lat = 1;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    do_reset();
    repeat (8) @(negedge clk);
    redirect_to(32'h0000_0200);
    repeat (20) @(negedge clk);
    checks++; if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h200) $display("[TB] FAIL collision_first_pc: got %h, expected 200", pop_pcs.size() ? pop_pcs[0] : 32'hx); else passes++;
    bus.mem_req_ready = 1'b0;
    repeat (10) @(negedge clk);
    bus.out_ready = 1'b0;
    a0 = acc_count;
    bus.mem_req_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (acc_count - a0 != 4) $display("[TB] FAIL collision_idle_credit: got %0d, expected 4", acc_count - a0); else passes++;
    checks++; if (bus.mem_req_valid !== 1'b0) $display("[TB] FAIL collision_req_valid: got %b, expected 0", bus.mem_req_valid); else passes++;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    mem_lat = 2;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    do_reset();
    repeat (6) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    redirect_to(32'h0000_0400);
    repeat (30) @(negedge clk);
    checks++; if (acc_addrs.size() == 0 || acc_addrs[0] !== 32'h400) $display("[TB] FAIL b2b_req_addr: got %h, expected 400", acc_addrs.size() ? acc_addrs[0] : 32'hx); else passes++;
    checks++; if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h400) $display("[TB] FAIL b2b_first_pc: got %h, expected 400", pop_pcs.size() ? pop_pcs[0] : 32'hx); else passes++;
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    redirect_to(32'hFFFF_FFF8);
    repeat (20) @(negedge clk);
    checks++;
    if (acc_addrs.size() < 3 || acc_addrs[0] !== 32'hFFFF_FFF8 || acc_addrs[1] !== 32'hFFFF_FFFC || acc_addrs[2] !== 32'h0)
      $display("[TB] FAIL wrap_req_addrs: got %0d addrs, expected FFFFFFF8,FFFFFFFC,00000000", acc_addrs.size());
    else passes++;
    checks++; if (pop_pcs.size() < 2 || pop_pcs[1] !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_pc: got %h, expected FFFFFFFC", pop_pcs.size() > 1 ? pop_pcs[1] : 32'hx); else passes++;
    checks++; if (pop_p4.size() < 2 || pop_p4[1] !== 32'h0) $display("[TB] FAIL wrap_pc_plus_4: got %h, expected 0", pop_p4.size() > 1 ? pop_p4[1] : 32'hx); else passes++;
  endtask

  task automatic test_reset_midop();
    mem_lat = 3;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    redirect_to(32'h0000_0800);
    repeat (6) @(negedge clk);
    do_reset();
    repeat (12) @(negedge clk);
    checks++; if (acc_addrs.size() == 0 || acc_addrs[0] !== 32'h0) $display("[TB] FAIL midrst_req_addr: got %h, expected 0", acc_addrs.size() ? acc_addrs[0] : 32'hx); else passes++;
    checks++; if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h0) $display("[TB] FAIL midrst_first_pc: got %h, expected 0", pop_pcs.size() ? pop_pcs[0] : 32'hx); else passes++;
  endtask

  task automatic test_random();
    int p0;
    mem_lat = 2;
    do_reset();
    p0 = pop_count;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.out_ready     = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom & 32'h0000_FFFF;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.out_ready      = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (sb.size() != 0) $display("[TB] FAIL random_lost: got %0d undelivered, expected 0", sb.size()); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL random_idle_out_valid: got %b, expected 0", bus.out_valid); else passes++;
    checks++; if (pop_count - p0 < 50) $display("[TB] FAIL random_progress: got %0d pops, expected at least 50", pop_count - p0); else passes++;
  endtask

  // Scenario sequence
  initial begin
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.out_ready      = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_redirect();
    test_misalign();
    test_collision();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
